// File: rtl/mem_arbiter_pkg.sv
// Shared types for the memory arbiter and its round-robin picker.
//   word_t    : memory data/address word
//   arb_id_t  : requester index, wide enough for the largest arbiter (8 requesters)
//   mem_req_t : one access as presented to the memory port
//   mem_rsp_t : one response-pipeline stage {valid, id, wr}
package mem_arbiter_pkg;
  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [2:0] arb_id_t;

  typedef struct packed {
    word_t addr;
    word_t din;
    logic  write_en;
  } mem_req_t;

  typedef struct packed {
    logic    valid;
    arb_id_t id;
    logic    wr;
  } mem_rsp_t;
endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Combinational round-robin picker: selects the first set bit of i_req at or
// after i_ptr, searching upward and wrapping modulo N.
// Ports:
//   i_req [N]   : request vector
//   i_ptr [IDW] : search start index (must be < N)
//   o_gnt [N]   : one-hot grant, zero when nothing requests
//   o_idx [IDW] : encoded index of the grant (0 when o_any = 0)
//   o_any       : some request was granted
module rr_pick #(
  parameter int N = 4,
  localparam int IDW = $clog2(N)
) (
  input  logic [N-1:0]   i_req,
  input  logic [IDW-1:0] i_ptr,
  output logic [N-1:0]   o_gnt,
  output logic [IDW-1:0] o_idx,
  output logic           o_any
);
  logic [IDW-1:0] w_cand;

  always_comb begin
    o_gnt  = '0;
    o_idx  = '0;
    o_any  = 1'b0;
    w_cand = '0;
    for (int k = 0; k < N; k++) begin
      w_cand = IDW'((int'(i_ptr) + k) % N);
      if (!o_any && i_req[w_cand]) begin
        o_gnt[w_cand] = 1'b1;
        o_idx         = w_cand;
        o_any         = 1'b1;
      end
    end
  end
endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one pipelined data-memory port among N
// requesters, routing each response back to its owner after LAT cycles.
//
// Handshake: an access from requester i is accepted in any cycle where
// req[i] and gnt[i] are both high. gnt is only raised while mem_ready is high,
// at most one bit per cycle. Request fields must hold steady while req is high
// and gnt is low. The response arrives exactly LAT cycles after acceptance as
// a one-cycle pulse on rsp_valid[i]; it cannot be back-pressured.
//
// Ports:
//   clk, rst (async, active low)
//   req / req_addr / req_din / req_write_en : per-requester access
//   gnt          : one-hot grant
//   rsp_valid    : one-hot response strobe; rsp_dout carries read data (0 for writes)
//   mem_ready    : memory accepts an access this cycle
//   mem_addr / mem_din / mem_write_en : drive to memory, zero when idle
//   mem_dout     : memory read data, valid LAT cycles after issue
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int N   = 4,
  parameter int LAT = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N-1:0]            req,
  input  logic [N-1:0][WORD_W-1:0] req_addr,
  input  logic [N-1:0][WORD_W-1:0] req_din,
  input  logic [N-1:0]            req_write_en,
  output logic [N-1:0]            gnt,
  output logic [N-1:0]            rsp_valid,
  output word_t                   rsp_dout,
  input  logic                    mem_ready,
  output word_t                   mem_addr,
  output word_t                   mem_din,
  output logic                    mem_write_en,
  input  word_t                   mem_dout
);
  localparam int IDW = $clog2(N);

  logic [N-1:0]   w_eligible;
  logic [N-1:0]   w_gnt;
  logic [IDW-1:0] w_idx;
  logic           w_any;
  logic [IDW-1:0] r_ptr;
  mem_req_t       w_sel;
  mem_rsp_t       w_stage0;
  mem_rsp_t       w_last;
  mem_rsp_t       r_pipe [LAT];

  // Gating with rst keeps the bus quiet while reset is held, even though the
  // picker itself is purely combinational.
  assign w_eligible = (mem_ready && rst) ? req : '0;

  rr_pick #(.N(N)) u_pick (
    .i_req (w_eligible),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  assign gnt = w_gnt;

  always_comb begin
    w_sel = '0;
    if (w_any) begin
      w_sel.addr     = req_addr[w_idx];
      w_sel.din      = req_din[w_idx];
      w_sel.write_en = req_write_en[w_idx];
    end
  end

  assign mem_addr     = w_sel.addr;
  assign mem_din      = w_sel.din;
  assign mem_write_en = w_sel.write_en;

  // Pointer moves one past the winner so it becomes lowest priority next.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr <= '0;
    end else if (w_any) begin
      r_ptr <= (w_idx == IDW'(N-1)) ? '0 : w_idx + 1'b1;
    end
  end

  always_comb begin
    w_stage0 = '0;
    if (w_any) begin
      w_stage0.valid = 1'b1;
      w_stage0.id    = arb_id_t'(w_idx);
      w_stage0.wr    = w_sel.write_en;
    end
  end

  // Tracks ownership of in-flight accesses; shifts every cycle regardless of
  // mem_ready because the memory pipeline itself never stalls.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 0; s < LAT; s++) r_pipe[s] <= '0;
    end else begin
      r_pipe[0] <= w_stage0;
      for (int s = 1; s < LAT; s++) r_pipe[s] <= r_pipe[s-1];
    end
  end

  assign w_last = r_pipe[LAT-1];

  always_comb begin
    rsp_valid = '0;
    for (int i = 0; i < N; i++) begin
      if (w_last.valid && (w_last.id == arb_id_t'(i))) rsp_valid[i] = 1'b1;
    end
  end

  // Writes are acknowledged with zero data so rsp_dout never leaks stale reads.
  assign rsp_dout = (w_last.valid && !w_last.wr) ? mem_dout : '0;
endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int N = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                     rst;
  logic                     mem_ready;
  logic                     mem_load;
  logic [N-1:0]             req;
  logic [N-1:0]             req_write_en;
  logic [N-1:0][WORD_W-1:0] req_addr;
  logic [N-1:0][WORD_W-1:0] req_din;

  logic [N-1:0] gnt1, gnt3, rv1, rv3;
  word_t        rd1, rd3, ma1, ma3, md1, md3, mo1, mo3;
  logic         mw1, mw3;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // {due cycle[51:36], one-hot id[35:32], data[31:0]}
  logic [51:0] exp_q1[$];
  logic [51:0] exp_q3[$];

  mem_arbiter #(.N(N), .LAT(1)) dut1 (
    .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .req_din(req_din),
    .req_write_en(req_write_en), .gnt(gnt1), .rsp_valid(rv1), .rsp_dout(rd1),
    .mem_ready(mem_ready), .mem_addr(ma1), .mem_din(md1), .mem_write_en(mw1),
    .mem_dout(mo1)
  );

  mem_arbiter #(.N(N), .LAT(3)) dut3 (
    .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .req_din(req_din),
    .req_write_en(req_write_en), .gnt(gnt3), .rsp_valid(rv3), .rsp_dout(rd3),
    .mem_ready(mem_ready), .mem_addr(ma3), .mem_din(md3), .mem_write_en(mw3),
    .mem_dout(mo3)
  );

  // ---------------- memory models ----------------
  logic [31:0] mem1 [256];
  logic [31:0] mem3 [256];
  logic [31:0] d1, d3a, d3b, d3c;

  function automatic logic [31:0] pat(input int i);
    if (i == 16) return 32'hDEADBEEF;
    return 32'h1000_0000 + 32'(i) * 32'h0001_0101;
  endfunction

  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 256; i++) mem1[i] <= pat(i);
    end else if (mw1) begin
      mem1[ma1[7:0]] <= md1;
    end
    d1 <= mem1[ma1[7:0]];
  end
  assign mo1 = d1;

  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 256; i++) mem3[i] <= pat(i);
    end else if (mw3) begin
      mem3[ma3[7:0]] <= md3;
    end
    d3a <= mem3[ma3[7:0]];
    d3b <= d3a;
    d3c <= d3b;
  end
  assign mo3 = d3c;

  // ---------------- checking ----------------
  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", nm, cyc, act, exp);
    end
  endtask

  task automatic zero_chk(input string nm);
    check({nm, ":gnt1"}, 64'(gnt1), 64'd0);
    check({nm, ":gnt3"}, 64'(gnt3), 64'd0);
    check({nm, ":rv1"},  64'(rv1), 64'd0);
    check({nm, ":rv3"},  64'(rv3), 64'd0);
    check({nm, ":rd1"},  64'(rd1), 64'd0);
    check({nm, ":rd3"},  64'(rd3), 64'd0);
    check({nm, ":bus1"}, {ma1, md1[30:0], mw1}, 64'd0);
    check({nm, ":bus3"}, {ma3, md3[30:0], mw3}, 64'd0);
  endtask

  // ---------------- driver: one cycle ----------------
  task automatic step(input logic [3:0] rq, input logic rdy, input logic [3:0] wr,
                      input int eg, input string nm);
    logic [3:0]  oh;
    logic [31:0] e_addr, e_din, e1, e3;
    logic        e_we;
    logic [51:0] e;
    req          = rq;
    mem_ready    = rdy;
    req_write_en = wr;
    #1;
    oh = '0; e_addr = '0; e_din = '0; e_we = 1'b0;
    if (eg >= 0) begin
      oh[eg] = 1'b1;
      e_addr = req_addr[eg];
      e_din  = req_din[eg];
      e_we   = wr[eg];
    end
    check({nm, ":gnt1"}, 64'(gnt1), 64'(oh));
    check({nm, ":gnt3"}, 64'(gnt3), 64'(oh));
    check({nm, ":addr1"}, 64'(ma1), 64'(e_addr));
    check({nm, ":addr3"}, 64'(ma3), 64'(e_addr));
    check({nm, ":din_we1"}, 64'({md1, mw1}), 64'({e_din, e_we}));
    check({nm, ":din_we3"}, 64'({md3, mw3}), 64'({e_din, e_we}));

    if (exp_q1.size() > 0 && exp_q1[0][51:36] == 16'(cyc)) begin
      e = exp_q1.pop_front();
      check({nm, ":rsp_valid1"}, 64'(rv1), 64'(e[35:32]));
      check({nm, ":rsp_dout1"},  64'(rd1), 64'(e[31:0]));
    end else begin
      check({nm, ":rsp_idle1"}, 64'(rv1), 64'd0);
    end
    if (exp_q3.size() > 0 && exp_q3[0][51:36] == 16'(cyc)) begin
      e = exp_q3.pop_front();
      check({nm, ":rsp_valid3"}, 64'(rv3), 64'(e[35:32]));
      check({nm, ":rsp_dout3"},  64'(rd3), 64'(e[31:0]));
    end else begin
      check({nm, ":rsp_idle3"}, 64'(rv3), 64'd0);
    end

    if (eg >= 0) begin
      e1 = e_we ? 32'd0 : mem1[e_addr[7:0]];
      e3 = e_we ? 32'd0 : mem3[e_addr[7:0]];
      exp_q1.push_back({16'(cyc + 1), oh, e1});
      exp_q3.push_back({16'(cyc + 3), oh, e3});
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  // ---------------- vector table ----------------
  typedef struct packed {
    logic [3:0] rq;
    logic       rdy;
    int         eg;
  } vec_t;

  vec_t tbl [23];

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d actual=timeout required=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    // Grant expectations derived by hand from the round-robin pointer walk.
    tbl[0]  = '{4'b0100, 1'b1, 2};   // single read of 0x10, ptr -> 3
    tbl[1]  = '{4'b0000, 1'b1, -1};
    tbl[2]  = '{4'b1111, 1'b1, 3};   // ptr was 3
    tbl[3]  = '{4'b1111, 1'b1, 0};
    tbl[4]  = '{4'b1111, 1'b1, 1};
    tbl[5]  = '{4'b1111, 1'b1, 2};
    tbl[6]  = '{4'b1111, 1'b1, 3};
    tbl[7]  = '{4'b1111, 1'b1, 0};
    tbl[8]  = '{4'b1111, 1'b0, -1};  // memory stalled three cycles
    tbl[9]  = '{4'b1111, 1'b0, -1};
    tbl[10] = '{4'b1111, 1'b0, -1};
    tbl[11] = '{4'b1111, 1'b1, 1};   // resumes at frozen ptr=1
    tbl[12] = '{4'b1010, 1'b1, 3};
    tbl[13] = '{4'b1010, 1'b1, 1};
    tbl[14] = '{4'b0001, 1'b1, 0};
    tbl[15] = '{4'b0100, 1'b1, 2};   // ptr -> 3
    tbl[16] = '{4'b0011, 1'b1, 0};   // 0 granted at ptr=3, ptr wraps to 1
    tbl[17] = '{4'b0011, 1'b1, 1};
    tbl[18] = '{4'b0001, 1'b1, 0};
    tbl[19] = '{4'b0001, 1'b1, 0};   // grant and response to 0 together
    tbl[20] = '{4'b0000, 1'b1, -1};
    tbl[21] = '{4'b0000, 1'b1, -1};
    tbl[22] = '{4'b0000, 1'b1, -1};

    req_addr[0] = 32'h04; req_addr[1] = 32'h08;
    req_addr[2] = 32'h10; req_addr[3] = 32'h0C;
    for (int i = 0; i < N; i++) req_din[i] = 32'hD000_0000 + 32'(i);

    // Reset with requests pending: bus must stay quiet.
    rst = 1'b0; mem_load = 1'b1; mem_ready = 1'b0; req = '0; req_write_en = '0;
    repeat (2) @(negedge clk);
    mem_load = 1'b0; req = 4'b1111; mem_ready = 1'b1;
    #1;
    zero_chk("reset_hold");
    rst = 1'b1;

    for (int v = 0; v < 23; v++) begin
      step(tbl[v].rq, tbl[v].rdy, 4'b0000, tbl[v].eg, $sformatf("vec%0d", v));
    end

    // Write then read the same address through different requesters (ptr=1).
    req_addr[1] = 32'h20; req_din[1] = 32'h0000_55AA;
    step(4'b0010, 1'b1, 4'b0010, 1, "wr1");
    req_addr[3] = 32'h20;
    step(4'b1000, 1'b1, 4'b0000, 3, "rd3");
    check("rd_after_wr_mem", 64'(mem1[8'h20]), 64'h55AA);
    for (int k = 0; k < 4; k++) step(4'b0000, 1'b1, 4'b0000, -1, "wr_rd_flush");

    // Async reset with accesses in flight (ptr=0 here).
    step(4'b1111, 1'b1, 4'b0000, 0, "pre_rst0");
    step(4'b1111, 1'b1, 4'b0000, 1, "pre_rst1");
    rst = 1'b0;
    #1;
    zero_chk("rst_async");
    exp_q1.delete();
    exp_q3.delete();
    @(posedge clk);
    @(negedge clk);
    zero_chk("rst_held");
    rst = 1'b1;
    step(4'b1111, 1'b1, 4'b0000, 0, "post_rst0");
    step(4'b1111, 1'b1, 4'b0000, 1, "post_rst1");
    step(4'b1111, 1'b1, 4'b0000, 2, "post_rst2");
    step(4'b1111, 1'b1, 4'b0000, 3, "post_rst3");
    step(4'b1111, 1'b1, 4'b0000, 0, "post_rst4");
    step(4'b1111, 1'b1, 4'b0000, 1, "post_rst5");
    for (int k = 0; k < 4; k++) step(4'b0000, 1'b1, 4'b0000, -1, "final_flush");

    check("q1_drained", 64'(exp_q1.size()), 64'd0);
    check("q3_drained", 64'(exp_q3.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
